fetch_unit: RTL and testbench

RV32I instruction fetch stage. It sits directly upstream of the instruction decoder. It owns the PC and issues word requests to instruction memory. It tracks in-flight requests, buffers returned instruction words alongside their PCs, and presents them one at a time to decode over a valid/ready handshake. Execute redirects it on taken branches and jumps; stale in-flight responses are discarded.

---
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: owns the PC, issues word requests to
// instruction memory under a credit limit, buffers returned words with their
// PCs and hands them to decode over a valid/ready handshake. Redirects from
// execute flush the buffer and discard responses that are still in flight.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW:0]   SUM_DEPTH = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  // Architectural state
  logic [31:0]   pcQ, pcD;
  logic [CW-1:0] inflightQ, inflightD;
  logic [CW-1:0] countQ, countD;
  logic [CW-1:0] dropQ, dropD;

  // In-flight PC FIFO: remembers which PC each outstanding request was for
  logic [31:0]   ifPcQ [DEPTH];
  logic [AW-1:0] ifWrQ, ifWrD;
  logic [AW-1:0] ifRdQ, ifRdD;

  // Output buffer: instruction words paired with their PCs
  logic [31:0]   bufPcQ    [DEPTH];
  logic [31:0]   bufInstrQ [DEPTH];
  logic [AW-1:0] bufWrQ, bufWrD;
  logic [AW-1:0] bufRdQ, bufRdD;

  // Per-cycle events
  logic          reqFire;
  logic          respKeep;
  logic          respDrop;
  logic          pushOut;
  logic          popOut;
  logic [CW:0]   creditSum;

  // Handshake decode and the credit limit that bounds in-flight plus buffered work
  always_comb begin
    creditSum      = {1'b0, inflightQ} + {1'b0, countQ};
    imem_req_valid = !rst && !redirect_valid && (creditSum < SUM_DEPTH);
    reqFire        = imem_req_valid && imem_req_ready;
    respKeep       = imem_resp_valid && (dropQ == '0);
    respDrop       = imem_resp_valid && (dropQ != '0);
    out_valid      = (countQ != '0);
    pushOut        = respKeep && !redirect_valid;
    popOut         = out_valid && out_ready && !redirect_valid;
    imem_addr      = pcQ;
  end

  // Present the buffer head; outputs read zero whenever nothing is buffered
  always_comb begin
    out_instruction = '0;
    out_pc          = '0;
    if (out_valid) begin
      out_instruction = bufInstrQ[bufRdQ];
      out_pc          = bufPcQ[bufRdQ];
    end
  end

  // Next-state for PC, counters and FIFO pointers; a redirect overrides everything
  always_comb begin
    pcD       = pcQ;
    inflightD = inflightQ;
    countD    = countQ;
    dropD     = dropQ;
    ifWrD     = ifWrQ;
    ifRdD     = ifRdQ;
    bufWrD    = bufWrQ;
    bufRdD    = bufRdQ;

    if (reqFire) begin
      ifWrD = ifWrQ + PTR_ONE;
    end
    if (imem_resp_valid) begin
      ifRdD = ifRdQ + PTR_ONE;
    end
    inflightD = inflightQ + (reqFire ? CNT_ONE : '0) - (imem_resp_valid ? CNT_ONE : '0);

    if (redirect_valid) begin
      pcD    = redirect_pc & 32'hFFFF_FFFC;
      countD = '0;
      bufRdD = bufWrQ;
      dropD  = inflightQ - (imem_resp_valid ? CNT_ONE : '0);
    end else begin
      if (reqFire) begin
        pcD = pcQ + 32'd4;
      end
      if (respDrop) begin
        dropD = dropQ - CNT_ONE;
      end
      if (pushOut) begin
        bufWrD = bufWrQ + PTR_ONE;
      end
      if (popOut) begin
        bufRdD = bufRdQ + PTR_ONE;
      end
      countD = countQ + (pushOut ? CNT_ONE : '0) - (popOut ? CNT_ONE : '0);
    end
  end

  // Control state register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcQ       <= RESET_PC;
      inflightQ <= '0;
      countQ    <= '0;
      dropQ     <= '0;
      ifWrQ     <= '0;
      ifRdQ     <= '0;
      bufWrQ    <= '0;
      bufRdQ    <= '0;
    end else begin
      pcQ       <= pcD;
      inflightQ <= inflightD;
      countQ    <= countD;
      dropQ     <= dropD;
      ifWrQ     <= ifWrD;
      ifRdQ     <= ifRdD;
      bufWrQ    <= bufWrD;
      bufRdQ    <= bufRdD;
    end
  end

  // FIFO storage needs no reset: counters decide which entries are meaningful
  always_ff @(posedge clk) begin
    if (reqFire) begin
      ifPcQ[ifWrQ] <= pcQ;
    end
    if (pushOut) begin
      bufPcQ[bufWrQ]    <= ifPcQ[ifRdQ];
      bufInstrQ[bufWrQ] <= imem_resp_data;
    end
  end

  // Design-error traps: buffer overflow and counter underflow must never happen
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(pushOut && !popOut && (countQ == CNT_DEPTH)));
      assert (!(reqFire && !imem_resp_valid && (inflightQ == CNT_DEPTH)));
      assert (!(imem_resp_valid && (inflightQ == '0)));
      assert (dropQ <= inflightQ);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a one-cycle-latency instruction memory model, a
// scoreboard queue of expected {pc} values, and directed scenarios covering
// reset, free-run, backpressure, redirects, alignment, wrap and mid-run reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  int          checks;
  int          errors;
  int          acceptCount;
  logic        memHold;
  logic [31:0] expQ [$];
  logic [31:0] memQ [$];

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_pc         (out_pc)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction word the memory model returns for a given address
  function automatic logic [31:0] wordFor(input logic [31:0] addr);
    return addr ^ 32'h1357_9BDF;
  endfunction

  // Memory model: records accepted requests and answers them in order one cycle later
  always begin : memModel
    logic        acceptNow;
    logic [31:0] acceptAddr;
    @(negedge clk);
    acceptNow  = imem_req_valid && imem_req_ready;
    acceptAddr = imem_addr;
    @(posedge clk);
    if (rst) begin
      memQ.delete();
      imem_resp_valid = 1'b0;
    end else begin
      if (acceptNow) begin
        memQ.push_back(acceptAddr);
        acceptCount++;
      end
      #1;
      if (!memHold && memQ.size() > 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = wordFor(memQ.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
      end
    end
  end

  // Consumer side: every instruction taken by decode is matched against the scoreboard
  always begin : monitor
    logic [31:0] expPc;
    @(negedge clk);
    if (!rst && out_valid && out_ready && !redirect_valid && expQ.size() > 0) begin
      expPc = expQ.pop_front();
      checks++;
      if (out_pc !== expPc) begin
        errors++;
        $display("[TB] FAIL out_pc: got %h expected %h", out_pc, expPc);
      end
      checks++;
      if (out_instruction !== wordFor(expPc)) begin
        errors++;
        $display("[TB] FAIL out_instruction @%h: got %h expected %h", expPc, out_instruction, wordFor(expPc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Advance one cycle, drive the execute/decode inputs, then let outputs settle
  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ordy);
    tick();
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ordy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic resetPulse();
    tick();
    rst         = 1'b1;
    acceptCount = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Let decode run until every expected instruction has been seen, within a budget
  task automatic drainExpected(input string name, input int maxCycles);
    for (int i = 0; i < maxCycles && expQ.size() != 0; i++) begin
      tick();
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s drain: got %0d left expected 0", name, expQ.size());
    end
    expQ.delete();
  endtask

  initial begin : stimulus
    logic found;
    checks          = 0;
    errors          = 0;
    acceptCount     = 0;
    memHold         = 1'b0;
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b1;

    // Reset values, then free-run from RESET_PC
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("rst out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("rst out_pc", out_pc, 32'h0);
    checkOutput("rst out_instruction", out_instruction, 32'h0);
    checkOutput("rst imem_addr", imem_addr, 32'h0);
    foreach (expQ[i]) expQ.delete(i);
    for (int i = 0; i < 6; i++) expQ.push_back(32'(i * 4));
    tick();
    rst = 1'b0;
    #1;
    checkOutput("first req_valid", {31'b0, imem_req_valid}, 32'h1);
    checkOutput("first imem_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("no bypass out_valid", {31'b0, out_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("first out_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("first out_pc", out_pc, 32'h0);
    drainExpected("freerun", 40);

    // Backpressure: credit stops requests at DEPTH, head holds still
    applyStimulus(1'b0, 32'h0, 1'b0);
    resetPulse();
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("bp accepted", 32'(acceptCount), 32'd2);
    checkOutput("bp req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("bp out_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("bp out_pc", out_pc, 32'h0);
    checkOutput("bp out_instruction", out_instruction, wordFor(32'h0));
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    expQ.push_back(32'h8);
    expQ.push_back(32'hC);
    applyStimulus(1'b0, 32'h0, 1'b1);
    drainExpected("backpressure", 40);

    // Redirect with two requests outstanding: both stale responses are dropped
    applyStimulus(1'b0, 32'h0, 1'b0);
    memHold = 1'b1;
    resetPulse();
    repeat (5) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("hold accepted", 32'(acceptCount), 32'd2);
    checkOutput("hold out_valid", {31'b0, out_valid}, 32'h0);
    expQ.push_back(32'h100);
    expQ.push_back(32'h104);
    expQ.push_back(32'h108);
    applyStimulus(1'b1, 32'h100, 1'b0);
    checkOutput("redirect cycle req_valid", {31'b0, imem_req_valid}, 32'h0);
    memHold = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redirect imem_addr", imem_addr, 32'h100);
    checkOutput("redirect flush out_valid", {31'b0, out_valid}, 32'h0);
    drainExpected("redirect stale", 40);

    // Redirect landing on a response and a decode pop, with a misaligned target
    applyStimulus(1'b0, 32'h0, 1'b1);
    resetPulse();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      if (imem_resp_valid && out_valid) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("coincide found", {31'b0, found}, 32'h1);
    expQ.push_back(32'h200);
    expQ.push_back(32'h204);
    expQ.push_back(32'h208);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    checkOutput("coincide req_valid", {31'b0, imem_req_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("aligned imem_addr", imem_addr, 32'h200);
    checkOutput("coincide flush out_valid", {31'b0, out_valid}, 32'h0);
    drainExpected("redirect coincide", 40);

    // Sequential fetch past the top of the address space wraps to zero
    applyStimulus(1'b0, 32'h0, 1'b0);
    expQ.push_back(32'hFFFF_FFF8);
    expQ.push_back(32'hFFFF_FFFC);
    expQ.push_back(32'h0000_0000);
    expQ.push_back(32'h0000_0004);
    applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("wrap imem_addr", imem_addr, 32'hFFFF_FFF8);
    drainExpected("wrap", 40);

    // Reset in the middle of the stream with the buffer full
    repeat (6) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("prereset out_valid", {31'b0, out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("midreset out_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("midreset req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("midreset out_pc", out_pc, 32'h0);
    checkOutput("midreset imem_addr", imem_addr, 32'h0);
    expQ.push_back(32'h0);
    expQ.push_back(32'h4);
    expQ.push_back(32'h8);
    tick();
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    checkOutput("restart req_valid", {31'b0, imem_req_valid}, 32'h1);
    drainExpected("restart", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
